// File: rtl/input_conditioner.sv
// Debounced, edge-detected button/switch inputs, one independent lane per channel.
// Define INPUT_COND_AUTOREPEAT_EN to build the per-channel auto-repeat counters.
module input_conditioner_lane #(
  parameter int N            = 4,
  parameter bit INV          = 1'b0,
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rep
);
  localparam int CW = $clog2(N);

  logic          r_sync1, r_s, r_level, r_rise, r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_diff, w_done;

  assign w_diff = r_s ^ r_level;
  // Nth consecutive differing cycle: accept the new level on this edge.
  assign w_done = w_diff && (r_cnt == CW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw ^ INV;
      r_s     <= r_sync1;
      r_rise  <= w_done &  r_s;
      r_fall  <= w_done & ~r_s;
      if (w_done) begin
        r_level <= r_s;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] r_rcnt;
  logic          r_rep;

  // Down-counter loaded on the same edge the level rises; a pulse fires on
  // the edge after it reaches zero, then it reloads with the repeat period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt <= '0;
      r_rep  <= 1'b0;
    end else if (w_done && r_s) begin
      r_rcnt <= RW'(REPEAT_DELAY-1);
      r_rep  <= 1'b0;
    end else if (w_done || !r_level) begin
      r_rcnt <= '0;
      r_rep  <= 1'b0;
    end else if (r_rcnt == '0) begin
      r_rcnt <= RW'(REPEAT_RATE-1);
      r_rep  <= 1'b1;
    end else begin
      r_rcnt <= r_rcnt - 1'b1;
      r_rep  <= 1'b0;
    end
  end

  assign rep = r_rep;
`else
  assign rep = 1'b0;
`endif
endmodule

module input_conditioner #(
  parameter int                  CHANNELS     = 4,
  parameter int                  DB_CYCLES    = 500000,
  parameter bit                  SIMULATION   = 1'b0,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW   = {CHANNELS{1'b0}},
  parameter int                  REPEAT_DELAY = 50000000,
  parameter int                  REPEAT_RATE  = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);
  localparam int N = SIMULATION ? 4 : DB_CYCLES;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    input_conditioner_lane #(
      .N            (N),
      .INV          (ACTIVE_LOW[ch]),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_in[ch]),
      .level (level_out[ch]),
      .rise  (rise_pulse[ch]),
      .fall  (fall_pulse[ch]),
      .rep   (repeat_pulse[ch])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: a history-based reference model pushes expected outputs
// every cycle; a negedge monitor pops and compares them against the DUT.
module tb_input_conditioner;
  localparam int       CH   = 4;
  localparam int       NEFF = 4;
  localparam int       RD   = 10;
  localparam int       RR   = 5;
  localparam bit [3:0] AL   = 4'b0100;

  logic          clk, rst;
  logic [CH-1:0] raw_in, level_out, rise_pulse, fall_pulse, repeat_pulse;

  input_conditioner #(
    .CHANNELS(CH), .DB_CYCLES(8), .SIMULATION(1'b1), .ACTIVE_LOW(AL),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .level_out(level_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] lvl, rise, fall, rep;
  } exp_t;

  exp_t     exp_q[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference: level flips once the last N synchronised samples all disagree
  // with it; repeats fall on fixed offsets from the rise cycle.
  bit [3:0] m_d1, m_s, m_lvl;
  bit [3:0] m_hist[$];
  int       m_rise_cyc[CH];

  always @(posedge clk) begin
    exp_t     e;
    bit [3:0] flip;
    cyc++;
    e    = '0;
    flip = '0;
    if (rst) begin
      m_d1 = '0; m_s = '0; m_lvl = '0;
      m_hist.delete();
    end else begin
      m_hist.push_front(m_s);
      if (m_hist.size() > NEFF) void'(m_hist.pop_back());
      for (int ch = 0; ch < CH; ch++) begin
        flip[ch] = (m_hist.size() == NEFF);
        foreach (m_hist[k]) if (m_hist[k][ch] == m_lvl[ch]) flip[ch] = 1'b0;
        if (flip[ch]) begin
          m_lvl[ch] = ~m_lvl[ch];
          if (m_lvl[ch]) begin
            e.rise[ch] = 1'b1;
            m_rise_cyc[ch] = cyc;
          end else begin
            e.fall[ch] = 1'b1;
          end
        end
`ifdef INPUT_COND_AUTOREPEAT_EN
        else if (m_lvl[ch] && (cyc - m_rise_cyc[ch] >= RD) &&
                 ((cyc - m_rise_cyc[ch] - RD) % RR == 0))
          e.rep[ch] = 1'b1;
`endif
      end
      m_s  = m_d1;
      m_d1 = raw_in ^ AL;
    end
    e.lvl = m_lvl;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("level_out",    int'(level_out),    int'(e.lvl));
      chk("rise_pulse",   int'(rise_pulse),   int'(e.rise));
      chk("fall_pulse",   int'(fall_pulse),   int'(e.fall));
      chk("repeat_pulse", int'(repeat_pulse), int'(e.rep));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle of the first rise pulse on a channel, -1 if none within the budget.
  task automatic first_rise(input int ch, output int c);
    c = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rise_pulse[ch]) begin
        c = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t, c, cnt, first;
    rst    = 1'b1;
    raw_in = 4'b0100;               // channel 2 is active-low: all idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("ch2_idle_after_reset", int'(level_out[2]), 0);

    // clean press on channel 0
    t = cyc;
    raw_in[0] = 1'b1;
    first_rise(0, c);
    chk("ch0_rise_latency", c, t + 6);
    tick();
    chk("ch0_rise_one_cycle", int'(rise_pulse[0]), 0);
    chk("ch0_level_held", int'(level_out[0]), 1);

    // auto-repeat while held
    cnt = 0; first = -1;
    for (int k = 0; k < 21; k++) begin
      tick();
      if (repeat_pulse[0]) begin
        cnt++;
        if (first < 0) first = cyc;
      end
    end
`ifdef INPUT_COND_AUTOREPEAT_EN
    chk("ch0_repeat_count", cnt, 3);
    chk("ch0_repeat_first", first, c + RD);
`else
    chk("ch0_repeat_count", cnt, 0);
`endif
    raw_in[0] = 1'b0;
    repeat (10) tick();
    chk("ch0_released", int'(level_out[0]), 0);

    // 3-cycle glitch on channel 1
    raw_in[1] = 1'b1;
    repeat (3) tick();
    raw_in[1] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (level_out[1] | rise_pulse[1] | fall_pulse[1]) cnt++;
    end
    chk("ch1_glitch_ignored", cnt, 0);

    // active-low press on channel 2
    t = cyc;
    raw_in[2] = 1'b0;
    first_rise(2, c);
    chk("ch2_rise_latency", c, t + 6);

    // channel 3 press interrupted by a one-cycle reset
    t = cyc;
    raw_in[3] = 1'b1;
    repeat (4) tick();
    chk("ch3_no_early_rise", int'(rise_pulse[3] | level_out[3]), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_clears_level", int'(level_out), 0);
    first_rise(3, c);
    chk("ch3_rise_after_reset", c, t + 11);

    // randomized bursts, occasional resets
    for (int i = 0; i < 80; i++) begin
      raw_in = 4'($urandom);
      rst    = ($urandom_range(0, 24) == 0);
      repeat ($urandom_range(1, 9)) tick();
      rst = 1'b0;
    end
    repeat (12) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
